pts_tx: RTL and testbench

Parallel-to-serial transmitter: the sending end of the serial link whose receiving end is `stp_4bit`. Accepts a `NUM_BITS` word through a valid/ready load handshake. Shifts the word out one bit per `shift_enable` strobe, using a bit counter and a two-state FSM. Pulses `done` at the end of each frame and supports back-to-back frames with no idle gap.

---
 rtl/pts_pkg.sv | 11 +
 rtl/pts_bit_counter.sv | 31 +++
 rtl/pts_tx.sv | 96 +++++++++
 tb/tb_pts_tx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pts_pkg.sv
// Shared types and constants for the pts_tx parallel-to-serial transmitter.
package pts_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } pts_state_t;

  localparam logic PTS_IDLE_BIT_DEFAULT = 1'b1;

endpackage

// File: rtl/pts_bit_counter.sv
// Bit counter with synchronous clear (priority over count) and a last flag
// asserted while the count equals a programmable rollover value.
module pts_bit_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_en,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)         count_d = '0;
    else if (count_en) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;
  assign last  = (count_q == rollover_val);

endmodule

// File: rtl/pts_tx.sv
// Parallel-to-serial transmitter with valid/ready load and back-to-back frames.
// Optional even-parity bit after the data bits when PTS_PARITY_EN is defined.
module pts_tx
  import pts_pkg::*;
#(
  parameter int   NUM_BITS  = 4,
  parameter int   SHIFT_MSB = 1,
  parameter logic IDLE_BIT  = PTS_IDLE_BIT_DEFAULT
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                load_valid,
  input  logic [NUM_BITS-1:0] parallel_in,
  output logic                load_ready,
  input  logic                shift_enable,
  output logic                serial_out,
  output logic                busy,
  output logic                done
);

`ifdef PTS_PARITY_EN
  localparam int FLEN = NUM_BITS + 1;
`else
  localparam int FLEN = NUM_BITS;
`endif
  localparam int CW = $clog2(NUM_BITS + 2);

  pts_state_t      state_q, state_d;
  logic [FLEN-1:0] sr_q, sr_d, load_word;
  logic            done_q;
  logic            cnt_last, last_bit, frame_end, load_acc;
  logic [CW-1:0]   cnt;

  assign last_bit  = (state_q == SHIFT) && cnt_last;
  assign frame_end = last_bit && shift_enable;
  assign load_acc  = load_valid && load_ready;

  pts_bit_counter #(.WIDTH(CW)) u_cnt (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (load_acc),
    .count_en     ((state_q == SHIFT) && shift_enable),
    .rollover_val (CW'(FLEN - 1)),
    .count        (cnt),
    .last         (cnt_last)
  );

  // Parity sits on the far side of the data so it leaves after the last data bit.
  always_comb begin
`ifdef PTS_PARITY_EN
    if (SHIFT_MSB != 0) load_word = {parallel_in, ^parallel_in};
    else                load_word = {^parallel_in, parallel_in};
`else
    load_word = parallel_in;
`endif
  end

  always_comb begin
    sr_d = sr_q;
    if (load_acc)
      sr_d = load_word;
    else if ((state_q == SHIFT) && shift_enable)
      sr_d = (SHIFT_MSB != 0) ? {sr_q[FLEN-2:0], IDLE_BIT} : {IDLE_BIT, sr_q[FLEN-1:1]};
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      sr_q    <= {FLEN{IDLE_BIT}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      done_q  <= frame_end;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_acc) state_d = SHIFT;
      SHIFT:   if (frame_end && !load_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == SHIFT);
    load_ready = (state_q == IDLE) || frame_end;
    done       = done_q;
    serial_out = IDLE_BIT;
    if (state_q == SHIFT)
      serial_out = (SHIFT_MSB != 0) ? sr_q[FLEN-1] : sr_q[0];
  end

endmodule

// File: tb/tb_pts_tx.sv
// Directed bench for pts_tx: queue-based frame model checked every cycle,
// plus literal expectations for the documented scenarios.
module tb_pts_tx;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          load_valid = 1'b0;
  logic [NB-1:0] parallel_in = '0;
  logic          shift_enable = 1'b0;
  logic          load_ready, serial_out, busy, done;

  int checks = 0;
  int failures = 0;

  pts_tx #(.NUM_BITS(NB)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .load_valid   (load_valid),
    .parallel_in  (parallel_in),
    .load_ready   (load_ready),
    .shift_enable (shift_enable),
    .serial_out   (serial_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a frame is just the list of bits still to be sent, in wire order.
  bit   mq[$];
  logic done_m = 1'b0;

  always @(posedge clk or negedge n_rst) begin
    bit rdy, fin, b;
    if (!n_rst) begin
      mq.delete();
      done_m = 1'b0;
    end else begin
      rdy = (mq.size() == 0) || (mq.size() == 1 && shift_enable);
      fin = 1'b0;
      if (shift_enable && mq.size() > 0) begin
        b = mq.pop_front();
        fin = (mq.size() == 0);
      end
      if (load_valid && rdy) begin
        for (int i = NB - 1; i >= 0; i--) mq.push_back(parallel_in[i]);
`ifdef PTS_PARITY_EN
        mq.push_back(^parallel_in);
`endif
      end
      done_m = fin;
    end
  end

  always @(negedge clk) begin
    chk("busy_model", busy, mq.size() != 0);
    chk("serial_model", serial_out, (mq.size() != 0) ? mq[0] : 1'b1);
    chk("done_model", done, done_m);
    chk("ready_model", load_ready, (mq.size() == 0) || (mq.size() == 1 && shift_enable));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    #1;
    chk("rst_serial", serial_out, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", load_ready, 1'b1);
    chk("rst_done", done, 1'b0);
    n_rst = 1'b1;
    step();

    // 1010, strobe held high
    load_valid = 1'b1; parallel_in = 4'b1010; shift_enable = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("a_bit", serial_out, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("a_nodone", done, 1'b0);
      step();
    end
    chk("a_done", done, 1'b1);
    chk("a_idle_serial", serial_out, 1'b1);
    chk("a_idle_busy", busy, 1'b0);
    step();
    chk("a_done_once", done, 1'b0);

    // 1000 with a 3-cycle stall after the first strobe
    shift_enable = 1'b0; load_valid = 1'b1; parallel_in = 4'b1000;
    step();
    load_valid = 1'b0;
    chk("b_bit0", serial_out, 1'b1);
    shift_enable = 1'b1;
    step();
    shift_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("b_stall", serial_out, 1'b0);
      step();
    end
    chk("b_stall_busy", busy, 1'b1);
    chk("b_stall_nodone", done, 1'b0);
    shift_enable = 1'b1;
    step();
    chk("b_bit2", serial_out, 1'b0);
    step();
    chk("b_bit3", serial_out, 1'b0);
    chk("b_nodone3", done, 1'b0);
    step();
    chk("b_done", done, 1'b1);
    shift_enable = 1'b0;
    step();

    // Back-to-back: 1100 then 0011 loaded on the final strobe
    shift_enable = 1'b1; load_valid = 1'b1; parallel_in = 4'b1100;
    step();
    load_valid = 1'b0;
    chk("c_bit0", serial_out, 1'b1); step();
    chk("c_bit1", serial_out, 1'b1); step();
    chk("c_bit2", serial_out, 1'b0); step();
    chk("c_bit3", serial_out, 1'b0);
    chk("c_ready_last", load_ready, 1'b1);
    load_valid = 1'b1; parallel_in = 4'b0011;
    step();
    load_valid = 1'b0;
    chk("c_done1", done, 1'b1);
    chk("c_busy_gapless", busy, 1'b1);
    chk("c_bit4", serial_out, 1'b0); step();
    chk("c_bit5", serial_out, 1'b0);
    chk("c_done1_once", done, 1'b0); step();
    chk("c_bit6", serial_out, 1'b1); step();
    chk("c_bit7", serial_out, 1'b1); step();
    chk("c_done2", done, 1'b1);
    chk("c_end_busy", busy, 1'b0);
    shift_enable = 1'b0;
    step();

    // Load ignored mid-frame, then reset mid-frame
    load_valid = 1'b1; parallel_in = 4'b1010;
    step();
    parallel_in = 4'b1111;
    chk("d_ready_busy", load_ready, 1'b0);
    shift_enable = 1'b1;
    step();
    load_valid = 1'b0;
    chk("d_unchanged", serial_out, 1'b0);
    step();
    chk("d_unchanged2", serial_out, 1'b1);
    #2 n_rst = 1'b0;
    #1;
    chk("d_rst_serial", serial_out, 1'b1);
    chk("d_rst_busy", busy, 1'b0);
    chk("d_rst_ready", load_ready, 1'b1);
    chk("d_rst_done", done, 1'b0);
    step();
    chk("d_rst_nodone", done, 1'b0);
    n_rst = 1'b1;
    shift_enable = 1'b0;
    step();

`ifdef PTS_PARITY_EN
    // 1011 -> parity 1 follows the data
    shift_enable = 1'b1; load_valid = 1'b1; parallel_in = 4'b1011;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("p_bit", serial_out, (i == 1) ? 1'b0 : 1'b1);
      chk("p_nodone", done, 1'b0);
      step();
    end
    chk("p_done", done, 1'b1);
    shift_enable = 1'b0;
    step();
`endif

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
